// File: rtl/laser_synchronizer.sv
// -----------------------------------------------------------------------------
// laser_synchronizer
//
// Fires a train of laser trigger pulses on every scan line of a resonant
// mirror. Each edge of the mirror zero-crossing level (zc_i) marks the start of
// a line. A line first reserves MEM_CYCLES_P cycles for data fetch, then fires
// POINTS_PER_LINE_P pulses, PULSE_LENGTH_P cycles high, one every "interval"
// cycles. The interval is derived from the measured mirror half-period freq_i
// at the start of the line. After LINES_PER_FRAME_P * NUMBER_OF_FRAMES_P lines
// the block goes silent until reset.
//
// Ports
//   clk_r            in   1   system clock, rising edge
//   nrst_r           in   1   asynchronous active-low reset
//   zc_i             in   1   mirror zero-crossing level (asynchronous)
//   freq_i           in  32   mirror half-period in clk_r cycles, sampled at
//                             each line start
//   laser_trigger_o  out  1   registered laser fire pulse, active-high
// -----------------------------------------------------------------------------
module laser_synchronizer #(
    parameter int SYSCLOCK_P         = 500000000,
    parameter int POINTS_PER_LINE_P  = 360,
    parameter int LINES_PER_FRAME_P  = 100,
    parameter int NUMBER_OF_FRAMES_P = 5,
    parameter int MEM_CYCLES_P       = 100,
    parameter int PULSE_LENGTH_P     = 5,
    parameter int THETAMAX_P         = 9
) (
    input  logic        clk_r,
    input  logic        nrst_r,
    input  logic        zc_i,
    input  logic [31:0] freq_i,
    output logic        laser_trigger_o
);

    localparam int PULSE_W = (POINTS_PER_LINE_P > 1) ? $clog2(POINTS_PER_LINE_P) : 1;
    localparam int LINE_W  = (LINES_PER_FRAME_P > 1) ? $clog2(LINES_PER_FRAME_P) : 1;
    localparam int FRAME_W = (NUMBER_OF_FRAMES_P > 1) ? $clog2(NUMBER_OF_FRAMES_P) : 1;

    localparam logic [31:0] MEM_C     = 32'(MEM_CYCLES_P);
    localparam logic [31:0] POINTS_C  = 32'(POINTS_PER_LINE_P);
    localparam logic [31:0] MIN_IV_C  = 32'(PULSE_LENGTH_P + 1);
    localparam logic [31:0] PL_LAST_C = 32'(PULSE_LENGTH_P - 1);
    // The event cycle itself is the first reserved cycle, so the state
    // machine only spends MEM_CYCLES_P-1 registered cycles in WAIT_MEM.
    localparam logic [31:0] MEM_LAST_C   = (MEM_CYCLES_P >= 2) ? 32'(MEM_CYCLES_P - 2) : 32'd0;
    localparam bit          DIRECT_FIRE_C = (MEM_CYCLES_P < 2);

    localparam logic [PULSE_W-1:0] PULSE_LAST_C = PULSE_W'(POINTS_PER_LINE_P - 1);
    localparam logic [LINE_W-1:0]  LINE_LAST_C  = LINE_W'(LINES_PER_FRAME_P - 1);
    localparam logic [FRAME_W-1:0] FRAME_LAST_C = FRAME_W'(NUMBER_OF_FRAMES_P - 1);

    // Reject parameter sets the timing scheme cannot represent.
    if (MEM_CYCLES_P < 1 || PULSE_LENGTH_P < 1 || POINTS_PER_LINE_P < 1 ||
        LINES_PER_FRAME_P < 1 || NUMBER_OF_FRAMES_P < 1 || SYSCLOCK_P < 1 ||
        THETAMAX_P < 1 || THETAMAX_P > 89) begin : g_param_check
        $error("laser_synchronizer: invalid parameter set");
    end

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_MEM  = 3'd1,
        FIRE      = 3'd2,
        GAP       = 3'd3,
        LINE_WAIT = 3'd4,
        DONE      = 3'd5
    } state_t;

    // Pulse spacing for a line: remaining half-period shared evenly between
    // the points, never shorter than one pulse plus one low cycle.
    function automatic logic [31:0] calc_interval(input logic [31:0] freq);
        logic [31:0] q;
        if (freq < MEM_C) begin
            q = MIN_IV_C;
        end else begin
            q = (freq - MEM_C) / POINTS_C;
            if (q < MIN_IV_C) begin
                q = MIN_IV_C;
            end else begin
                q = q;
            end
        end
        return q;
    endfunction

    logic               zc_meta_q, zc_meta_d;
    logic               zc_sync_q, zc_sync_d;
    logic               zc_prev_q, zc_prev_d;
    logic               line_evt_q, line_evt_d;
    state_t             state_q, state_d;
    logic [31:0]        cnt_q, cnt_d;
    logic [31:0]        interval_q, interval_d;
    logic [PULSE_W-1:0] pulse_q, pulse_d;
    logic [LINE_W-1:0]  line_q, line_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic               laser_q, laser_d;
    logic               last_line_s;

    assign last_line_s     = (line_q == LINE_LAST_C) && (frame_q == FRAME_LAST_C);
    assign laser_trigger_o = laser_q;

    // Two-flop synchronizer plus edge detector producing the line-start event.
    always_comb begin
        zc_meta_d  = zc_i;
        zc_sync_d  = zc_meta_q;
        zc_prev_d  = zc_sync_q;
        line_evt_d = zc_sync_q ^ zc_prev_q;
    end

    // Next-state, counters and pulse output of the line sequencer.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        interval_d = interval_q;
        pulse_d    = pulse_q;
        line_d     = line_q;
        frame_d    = frame_q;
        laser_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (line_evt_q) begin
                    interval_d = calc_interval(freq_i);
                    cnt_d      = 32'd0;
                    pulse_d    = '0;
                    state_d    = DIRECT_FIRE_C ? FIRE : WAIT_MEM;
                    laser_d    = DIRECT_FIRE_C;
                end else begin
                    state_d = IDLE;
                end
            end

            WAIT_MEM, FIRE, GAP, LINE_WAIT: begin
                if (line_evt_q) begin
                    // A new line start closes the current line, whatever it
                    // was doing; an in-flight pulse is cut short.
                    if (last_line_s) begin
                        state_d = DONE;
                    end else begin
                        if (line_q == LINE_LAST_C) begin
                            line_d  = '0;
                            frame_d = frame_q + FRAME_W'(1);
                        end else begin
                            line_d = line_q + LINE_W'(1);
                        end
                        interval_d = calc_interval(freq_i);
                        cnt_d      = 32'd0;
                        pulse_d    = '0;
                        state_d    = DIRECT_FIRE_C ? FIRE : WAIT_MEM;
                        laser_d    = DIRECT_FIRE_C;
                    end
                end else begin
                    case (state_q)
                        WAIT_MEM: begin
                            if (cnt_q == MEM_LAST_C) begin
                                state_d = FIRE;
                                cnt_d   = 32'd0;
                                laser_d = 1'b1;
                            end else begin
                                cnt_d = cnt_q + 32'd1;
                            end
                        end
                        FIRE: begin
                            cnt_d = cnt_q + 32'd1;
                            if (cnt_q == PL_LAST_C) begin
                                laser_d = 1'b0;
                                state_d = (pulse_q == PULSE_LAST_C) ? LINE_WAIT : GAP;
                            end else begin
                                laser_d = 1'b1;
                            end
                        end
                        GAP: begin
                            // cnt runs from the rise of the pulse, so the next
                            // rise comes exactly one interval later.
                            if (cnt_q == interval_q - 32'd1) begin
                                state_d = FIRE;
                                cnt_d   = 32'd0;
                                pulse_d = pulse_q + PULSE_W'(1);
                                laser_d = 1'b1;
                            end else begin
                                cnt_d = cnt_q + 32'd1;
                            end
                        end
                        default: begin
                            state_d = state_q;
                        end
                    endcase
                end
            end

            DONE: begin
                state_d = DONE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously by nrst_r.
    always_ff @(posedge clk_r or negedge nrst_r) begin
        if (!nrst_r) begin
            zc_meta_q  <= 1'b0;
            zc_sync_q  <= 1'b0;
            zc_prev_q  <= 1'b0;
            line_evt_q <= 1'b0;
            state_q    <= IDLE;
            cnt_q      <= 32'd0;
            interval_q <= 32'd0;
            pulse_q    <= '0;
            line_q     <= '0;
            frame_q    <= '0;
            laser_q    <= 1'b0;
        end else begin
            zc_meta_q  <= zc_meta_d;
            zc_sync_q  <= zc_sync_d;
            zc_prev_q  <= zc_prev_d;
            line_evt_q <= line_evt_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            interval_q <= interval_d;
            pulse_q    <= pulse_d;
            line_q     <= line_d;
            frame_q    <= frame_d;
            laser_q    <= laser_d;
        end
    end

endmodule

// File: tb/tb_laser_synchronizer.sv
// -----------------------------------------------------------------------------
// Testbench for laser_synchronizer with a reduced parameter set so whole
// frame sequences fit in a short run. The reference model derives the expected
// trigger level of every cycle from the list of line-start times: pulse k of
// line j is high for PL cycles starting at E_j + MEM + k*interval_j, cut off
// after the next line start, and only the first LINES*FRAMES lines fire.
// -----------------------------------------------------------------------------
module tb_laser_synchronizer;

    localparam int PTS    = 4;
    localparam int LINES  = 3;
    localparam int FRAMES = 2;
    localparam int MEM    = 10;
    localparam int PL     = 3;
    localparam int TOTAL  = LINES * FRAMES;

    logic        clk_r = 1'b0;
    logic        nrst_r;
    logic        zc_i;
    logic [31:0] freq_i;
    logic        laser_trigger_o;

    always #5 clk_r = ~clk_r;

    laser_synchronizer #(
        .SYSCLOCK_P(100000000),
        .POINTS_PER_LINE_P(PTS),
        .LINES_PER_FRAME_P(LINES),
        .NUMBER_OF_FRAMES_P(FRAMES),
        .MEM_CYCLES_P(MEM),
        .PULSE_LENGTH_P(PL),
        .THETAMAX_P(9)
    ) dut (
        .clk_r(clk_r),
        .nrst_r(nrst_r),
        .zc_i(zc_i),
        .freq_i(freq_i),
        .laser_trigger_o(laser_trigger_o)
    );

    typedef struct {
        logic [31:0] freq;
        int          period;
        int          exp_rises;
        int          exp_first;
    } vec_t;

    int     errors = 0;
    int     checks = 0;
    int     shown  = 0;
    int     cyc    = 0;
    int     rises  = 0;
    int     first_rise = -1;
    logic   prev_out = 1'b0;
    int     e_t[$];
    longint iv_q[$];
    vec_t   vecs[8];

    function automatic longint ref_interval(input logic [31:0] f);
        longint fl;
        longint q;
        fl = longint'(f);
        if (fl < longint'(MEM)) return longint'(PL + 1);
        q = (fl - longint'(MEM)) / longint'(PTS);
        if (q < longint'(PL + 1)) return longint'(PL + 1);
        return q;
    endfunction

    function automatic logic ref_out(input int c);
        logic   r;
        longint off;
        int     n;
        r = 1'b0;
        n = e_t.size();
        for (int j = 0; j < n && j < TOTAL; j++) begin
            if (e_t[j] < c && (j + 1 >= n || c <= e_t[j + 1])) begin
                off = longint'(c) - longint'(e_t[j]) - longint'(MEM);
                if (off >= 64'sd0 && (off / iv_q[j]) < longint'(PTS) &&
                    (off % iv_q[j]) < longint'(PL)) begin
                    r = 1'b1;
                end
            end
        end
        return r;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            if (shown < 40) begin
                $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
            end
            shown++;
        end
    endtask

    task automatic step();
        @(negedge clk_r);
        cyc++;
        check("trace", int'(laser_trigger_o), int'(ref_out(cyc)));
        if (laser_trigger_o && !prev_out) begin
            rises++;
            if (first_rise < 0) first_rise = cyc;
        end
        prev_out = laser_trigger_o;
    endtask

    task automatic toggle(input logic [31:0] f);
        freq_i = f;
        zc_i   = ~zc_i;
        e_t.push_back(cyc + 3);
        iv_q.push_back(ref_interval(f));
    endtask

    task automatic do_reset(input logic zc_level, input logic [31:0] f);
        nrst_r = 1'b0;
        zc_i   = zc_level;
        freq_i = f;
        repeat (3) begin
            @(negedge clk_r);
            check("reset_out", int'(laser_trigger_o), 0);
        end
        nrst_r     = 1'b1;
        cyc        = 0;
        rises      = 0;
        first_rise = -1;
        prev_out   = 1'b0;
        e_t.delete();
        iv_q.delete();
        // A level already high when reset releases is a 0->1 edge to the
        // cleared synchronizer.
        if (zc_level) begin
            e_t.push_back(3);
            iv_q.push_back(ref_interval(f));
        end
    endtask

    initial begin
        int          t0;
        logic [31:0] f;

        nrst_r = 1'b0;
        zc_i   = 1'b0;
        freq_i = 32'd0;

        vecs[0] = '{32'd50,         60, 24, 13};
        vecs[1] = '{32'd20,         60, 24, 13};
        vecs[2] = '{32'd5,          60, 24, 13};
        vecs[3] = '{32'd50,         35, 18, 13};
        vecs[4] = '{32'd50,         31, 18, 13};
        vecs[5] = '{32'd1000,       60,  6, 13};
        vecs[6] = '{32'd50,          8,  0, -1};
        vecs[7] = '{32'hFFFF_FFFF,  60,  6, 13};

        // Table: fixed period and freq, run past the last line of the last frame.
        for (int v = 0; v < 8; v++) begin
            do_reset(1'b0, 32'd0);
            repeat (5) step();
            t0 = cyc;
            for (int t = 0; t < TOTAL + 2; t++) begin
                toggle(vecs[v].freq);
                repeat (vecs[v].period) step();
            end
            repeat (30) step();
            check($sformatf("vec%0d_rises", v), rises, vecs[v].exp_rises);
            check($sformatf("vec%0d_first", v),
                  (first_rise < 0) ? -1 : first_rise - t0, vecs[v].exp_first);
        end

        // Randomized line starts and half-periods against the model.
        for (int p = 0; p < 3; p++) begin
            do_reset(1'b0, 32'd0);
            repeat (3) step();
            for (int t = 0; t < 20; t++) begin
                case ($urandom_range(0, 2))
                    0:       f = 32'($urandom_range(0, 40));
                    1:       f = 32'($urandom_range(40, 400));
                    default: f = $urandom();
                endcase
                toggle(f);
                repeat ($urandom_range(4, 90)) step();
            end
            repeat (50) step();
        end

        // Reset in the middle of a pulse drops the output at once.
        do_reset(1'b0, 32'd50);
        repeat (2) step();
        toggle(32'd50);
        for (int i = 0; i < 100 && !laser_trigger_o; i++) step();
        check("fire_seen", int'(laser_trigger_o), 1);
        #2 nrst_r = 1'b0;
        #1 check("async_drop", int'(laser_trigger_o), 0);
        do_reset(1'b0, 32'd50);
        repeat (60) step();
        check("quiet_after_reset", rises, 0);
        t0 = cyc;
        toggle(32'd50);
        repeat (40) step();
        check("restart_first", (first_rise < 0) ? -1 : first_rise - t0, 13);

        // zc already high at release starts line 0 without another edge.
        do_reset(1'b1, 32'd50);
        repeat (60) step();
        check("zc_high_first", first_rise, 13);
        check("zc_high_rises", rises, 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/laser_synchronizer.md
LASER_SYNCHRONIZER -- requirements
Module: laser_synchronizer

Interface
REQ-001 Parameter SYSCLOCK_P, default 500000000: system clock frequency in Hz; informational, no effect on timing.
REQ-002 Parameter POINTS_PER_LINE_P, default 360: laser pulses fired per scan line (one mirror half-period).
REQ-003 Parameter LINES_PER_FRAME_P, default 100: scan lines per frame.
REQ-004 Parameter NUMBER_OF_FRAMES_P, default 5: frames emitted after reset before the block goes silent.
REQ-005 Parameter MEM_CYCLES_P, default 100: clock cycles reserved at each line start (data fetch) before the first pulse.
REQ-006 Parameter PULSE_LENGTH_P, default 5: laser trigger high time in clock cycles.
REQ-007 Parameter THETAMAX_P, default 9: mirror mechanical half-angle in degrees; informational in this revision, no effect on timing.
REQ-008 clk_r  input  1  system clock; all logic on rising edge.
REQ-009 nrst_r  input  1  reset, asynchronous, active-low.
REQ-010 zc_i  input  1  mirror zero-crossing level; toggles once per mirror half-period; each edge (rise or fall) marks a line start.
REQ-011 freq_i  input  32  mirror half-period in clk_r cycles (unsigned); sampled at each line start.
REQ-012 laser_trigger_o  output  1  laser fire pulse, registered, active-high.

Function
REQ-013 zc_i SHALL pass through a 2-flop synchronizer; a line-start event E SHALL be flagged one cycle after the synchronized level changes (3 cycles after the zc_i change).
REQ-014 At E the block SHALL register interval = (freq_i - MEM_CYCLES_P) / POINTS_PER_LINE_P (integer floor, 32-bit), clamped to a minimum of PULSE_LENGTH_P+1; if freq_i < MEM_CYCLES_P, interval SHALL be PULSE_LENGTH_P+1.
REQ-015 States: IDLE (wait first E), WAIT_MEM, FIRE, GAP, LINE_WAIT, DONE.
REQ-016 IDLE -> WAIT_MEM on E; WAIT_MEM lasts MEM_CYCLES_P cycles, then FIRE.
REQ-017 Pulse k (k = 0..POINTS_PER_LINE_P-1) SHALL rise at cycle E + MEM_CYCLES_P + k*interval and stay high exactly PULSE_LENGTH_P cycles (FIRE), then low in GAP for the rest of interval.
REQ-018 After pulse POINTS_PER_LINE_P-1 completes, state SHALL be LINE_WAIT with output low until next E.
REQ-019 An E arriving in any of WAIT_MEM/FIRE/GAP/LINE_WAIT SHALL abort the remaining pulses of the current line (output low the next cycle, pulse truncated), count the line as complete, and start a new line (WAIT_MEM) from that E.
REQ-020 Line counter (0..LINES_PER_FRAME_P-1) and frame counter (0..NUMBER_OF_FRAMES_P-1) SHALL advance on each line completion; line counter wraps to 0 and increments frame counter.
REQ-021 When the completed line is the last line of the last frame, state SHALL go to DONE: output held low, all E ignored until reset.
REQ-022 Counters SHALL be sized by $clog2 of their parameters; pulse counter sized for POINTS_PER_LINE_P; no overflow permitted.

Reset
REQ-023 While nrst_r low: laser_trigger_o = 0, state IDLE, all counters 0, interval 0, synchronizer flops 0, cleared asynchronously.
REQ-024 Reset asserted mid-pulse SHALL drop laser_trigger_o immediately; after release the first zc_i edge (or a zc_i already high, seen as a 0->1 transition of the synchronizer) starts line 0 of frame 0.

Verification
REQ-025 Defaults, freq_i=46296, zc_i toggling every 46297 cycles -> interval 128; first rising edge of laser_trigger_o at E+100, high 5 cycles, subsequent rises every 128 cycles, 360 pulses per line.
REQ-026 Same stimulus run to completion -> exactly 100*5*360 = 180000 pulses, then laser_trigger_o stays 0 for all further zc_i edges.
REQ-027 zc_i toggling early (every 20000 cycles, freq_i=46296) -> pulses per line truncated to those starting before next E (floor((20000-100-1)/128)+1 = 156 counting sync latency alignment), new line restarts with pulse at E+100.
REQ-028 freq_i=600, POINTS_PER_LINE_P=360 -> interval clamped to 6; pulses 5 high / 1 low.
REQ-029 nrst_r pulsed low during FIRE -> output 0 within the same cycle; after release, no pulse until a new zc edge + 100 cycles.
